// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: sequential EX-stage ALU. Logic, arithmetic, shift, compare,
// count and HI/LO move ops complete in one cycle. MULT/MULTU/DIV/DIVU run
// iteratively for WIDTH cycles on operand magnitudes; signs are fixed at commit.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, func, a, b     op launch (accepted only while not busy)
//   result, z_flag        registered result and result==0 flag
//   busy                  multicycle op in flight
//   done                  one-cycle completion pulse
//   hi, lo                architectural HI/LO registers
module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             z_flag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_MAX = SW'(WIDTH - 1);
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  localparam logic [5:0] F_SLLV = 6'd4,  F_SRLV = 6'd6,  F_SRAV = 6'd7;
  localparam logic [5:0] F_MFHI = 6'd16, F_MTHI = 6'd17, F_MFLO = 6'd18, F_MTLO = 6'd19;
  localparam logic [5:0] F_MULT = 6'd24, F_MULTU = 6'd25, F_DIV = 6'd26, F_DIVU = 6'd27;
  localparam logic [5:0] F_ADD = 6'd32, F_ADDU = 6'd33, F_SUB = 6'd34, F_SUBU = 6'd35;
  localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_XOR = 6'd38, F_NOR = 6'd39;
  localparam logic [5:0] F_SLT = 6'd42, F_SLTU = 6'd43, F_CLZ = 6'd60, F_CLO = 6'd61;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   work_q, work_d;   // mul: {acc, multiplier}; div: {rem, dividend}
  logic [WIDTH-1:0]     dvs_q, dvs_d;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0]     res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic                 z_q, z_d, done_q, done_d;

  function automatic logic [WIDTH-1:0] lead_zeros(input logic [WIDTH-1:0] v);
    lead_zeros = WIDTH'(WIDTH);
    // Ascending scan: the highest set bit is the last to overwrite.
    for (int unsigned i = 0; i < WIDTH; i++)
      if (v[i]) lead_zeros = WIDTH'(WIDTH - 1 - i);
  endfunction

  // Single-cycle decode
  logic [WIDTH-1:0] sc_res;
  logic             sc_wr_hi, sc_wr_lo;
  logic [SW-1:0]    shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    sc_res   = '0;
    sc_wr_hi = 1'b0;
    sc_wr_lo = 1'b0;
    case (func)
      F_AND:          sc_res = a & b;
      F_OR:           sc_res = a | b;
      F_XOR:          sc_res = a ^ b;
      F_NOR:          sc_res = ~(a | b);
      F_ADD, F_ADDU:  sc_res = a + b;
      F_SUB, F_SUBU:  sc_res = a - b;
      F_SLT:          sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      F_SLTU:         sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      F_SLLV:         sc_res = a << shamt;
      F_SRLV:         sc_res = a >> shamt;
      F_SRAV:         sc_res = $unsigned($signed(a) >>> shamt);
      F_CLZ:          sc_res = lead_zeros(a);
      F_CLO:          sc_res = lead_zeros(~a);
      F_MFHI:         sc_res = hi_q;
      F_MFLO:         sc_res = lo_q;
      F_MTHI:         begin sc_res = a; sc_wr_hi = 1'b1; end
      F_MTLO:         begin sc_res = a; sc_wr_lo = 1'b1; end
      default:        sc_res = '0;
    endcase
  end

  // Accept-time operand magnitudes
  logic             is_mul, is_div, acc_sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign is_mul  = (func == F_MULT) || (func == F_MULTU);
  assign is_div  = (func == F_DIV)  || (func == F_DIVU);
  assign acc_sgn = ~func[0];
  assign mag_a   = (acc_sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b   = (acc_sgn && b[WIDTH-1]) ? -b : b;

  // One shift-add multiply step and one restoring divide step
  logic [WIDTH:0]     madd, dupper, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign madd     = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? dvs_q : '0)};
  assign mul_next = {madd, work_q[WIDTH-1:1]};
  assign dupper   = work_q[2*WIDTH-1:WIDTH-1];
  assign diff     = dupper - {1'b0, dvs_q};
  assign div_next = diff[WIDTH] ? {dupper[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   work_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -mul_next : mul_next;
  // Most-negative / -1 needs no special case: the negated magnitude wraps back.
  assign quot_fix = dz_q ? '1  : (neg_q  ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0]);
  assign rem_fix  = dz_q ? a_q : (rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    res_d   = res_q;
    z_d     = z_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            state_d = is_mul ? S_MUL : S_DIV;
            cnt_d   = CNT_MAX;
            work_d  = {{WIDTH{1'b0}}, mag_a};
            dvs_d   = mag_b;
            a_d     = a;
            neg_d   = acc_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = acc_sgn & a[WIDTH-1];
            dz_d    = (b == '0);
          end else begin
            res_d  = sc_res;
            z_d    = (sc_res == '0);
            done_d = 1'b1;
            if (sc_wr_hi) hi_d = a;
            if (sc_wr_lo) lo_d = a;
          end
        end
      end
      S_MUL: begin
        work_d = mul_next;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hi_d    = prod_fix[2*WIDTH-1:WIDTH];
          lo_d    = prod_fix[WIDTH-1:0];
          res_d   = prod_fix[WIDTH-1:0];
          z_d     = (prod_fix[WIDTH-1:0] == '0);
          done_d  = 1'b1;
        end
      end
      S_DIV: begin
        work_d = div_next;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hi_d    = rem_fix;
          lo_d    = quot_fix;
          res_d   = quot_fix;
          z_d     = (quot_fix == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      z_q     <= z_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign result = res_q;
  assign z_flag = z_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
module tb_alu_seq_muldiv;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  func = '0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result, hi, lo;
  logic        z_flag, busy, done;

  logic        start8 = 1'b0;
  logic [5:0]  func8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  result8, hi8, lo8;
  logic        z8, busy8, done8;

  int tests_run = 0;
  int failed = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  alu_seq_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .func(func), .a(a), .b(b),
    .result(result), .z_flag(z_flag), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  alu_seq_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .func(func8), .a(a8), .b(b8),
    .result(result8), .z_flag(z8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Behavioural reference: architectural effect of one op on result/HI/LO.
  function automatic void model32(input logic [5:0] f, input logic [31:0] x, y,
                                  output logic [31:0] r, output int lat);
    longint sx, sy, q, rm;
    logic [63:0] p;
    int n;
    sx = $signed(x);
    sy = $signed(y);
    r = '0;
    lat = 0;
    case (f)
      6'd36: r = x & y;
      6'd37: r = x | y;
      6'd38: r = x ^ y;
      6'd39: r = ~(x | y);
      6'd32, 6'd33: r = x + y;
      6'd34, 6'd35: r = x - y;
      6'd42: r = (sx < sy) ? 32'd1 : 32'd0;
      6'd43: r = (x < y) ? 32'd1 : 32'd0;
      6'd4:  r = x << y[4:0];
      6'd6:  r = x >> y[4:0];
      6'd7:  r = $unsigned($signed(x) >>> y[4:0]);
      6'd60: begin n = 0; while (n < 32 && x[31-n] == 1'b0) n++; r = n; end
      6'd61: begin n = 0; while (n < 32 && x[31-n] == 1'b1) n++; r = n; end
      6'd16: r = m_hi;
      6'd18: r = m_lo;
      6'd17: begin m_hi = x; r = x; end
      6'd19: begin m_lo = x; r = x; end
      6'd24, 6'd25: begin
        p = (f == 6'd24) ? 64'(sx * sy) : ({32'b0, x} * {32'b0, y});
        m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 32;
      end
      6'd26, 6'd27: begin
        if (y == 0) begin
          m_lo = '1; m_hi = x;
        end else if (f == 6'd26) begin
          q = sx / sy; rm = sx % sy;
          m_lo = q[31:0]; m_hi = rm[31:0];
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
        r = m_lo; lat = 32;
      end
      default: r = '0;
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'(1) << $urandom_range(0, 31);
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Drive one op, wait (bounded) for done; lat = edges after the accept edge.
  task automatic do_op32(input logic [5:0] f, input logic [31:0] x, y,
                         output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; func = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic do_op8(input logic [5:0] f, input logic [7:0] x, y,
                        output int lat);
    @(negedge clk);
    start8 = 1'b1; func8 = f; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done8) lat = -1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({result, z_flag, busy, done, hi, lo} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got r=%h z=%b busy=%b done=%b hi=%h lo=%h want all 0",
               result, z_flag, busy, done, hi, lo);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_reset_mid_mul();
    int lat, bc;
    logic [31:0] er;
    @(negedge clk);
    start = 1'b1; func = 6'd24; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({result, z_flag, busy, done, hi, lo} !== '0) begin
      failed++;
      $display("FAIL reset_mid_mul: got r=%h z=%b busy=%b done=%b hi=%h lo=%h want all 0",
               result, z_flag, busy, done, hi, lo);
    end
    @(negedge clk) reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    model32(6'd18, '0, '0, er, lat);
    do_op32(6'd18, '0, '0, lat, bc);
    tests_run++;
    if (result !== er || lat !== 0) begin
      failed++;
      $display("FAIL mflo_after_reset: got r=%h lat=%0d want r=%h lat=0", result, lat, er);
    end
  endtask

  task automatic test_single_directed();
    logic [5:0]  fs [6] = '{6'd34, 6'd42, 6'd43, 6'd60, 6'd61, 6'd33};
    logic [31:0] xs [6] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] ys [6] = '{32'd5, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1};
    logic [31:0] want [6] = '{32'd0, 32'd1, 32'd0, 32'd15, 32'd32, 32'h8000_0000};
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      do_op32(fs[i], xs[i], ys[i], lat, bc);
      tests_run++;
      if (result !== want[i] || z_flag !== (want[i] == 0) || lat !== 0) begin
        failed++;
        $display("FAIL single_directed[%0d]: got r=%h z=%b lat=%0d want r=%h z=%b lat=0",
                 i, result, z_flag, lat, want[i], (want[i] == 0));
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || result !== 32'h8000_0000) begin
      failed++;
      $display("FAIL done_pulse: got done=%b r=%h want done=0 r=80000000", done, result);
    end
  endtask

  task automatic test_random_single();
    logic [5:0] ops [21] = '{6'd36, 6'd37, 6'd38, 6'd39, 6'd32, 6'd33, 6'd34, 6'd35,
                             6'd42, 6'd43, 6'd4, 6'd6, 6'd7, 6'd60, 6'd61,
                             6'd16, 6'd17, 6'd18, 6'd19, 6'd63, 6'd0};
    logic [5:0]  f;
    logic [31:0] x, y, er;
    int el, lat, bc;
    for (int i = 0; i < 200; i++) begin
      f = ops[$urandom_range(0, 20)];
      x = rnd32();
      y = rnd32();
      model32(f, x, y, er, el);
      do_op32(f, x, y, lat, bc);
      tests_run++;
      if (result !== er || z_flag !== (er == 0) || hi !== m_hi || lo !== m_lo || lat !== el) begin
        failed++;
        $display("FAIL random_single f=%0d a=%h b=%h: got r=%h z=%b hi=%h lo=%h lat=%0d want r=%h z=%b hi=%h lo=%h lat=%0d",
                 f, x, y, result, z_flag, hi, lo, lat, er, (er == 0), m_hi, m_lo, el);
      end
    end
  endtask

  task automatic test_muldiv_directed();
    logic [5:0]  fs [6] = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd26, 6'd16};
    logic [31:0] xs [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd0};
    logic [31:0] ys [6] = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] whi [6] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd0};
    logic [31:0] wlo [6] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    int wlat [6] = '{32, 32, 32, 32, 32, 0};
    logic [31:0] wres;
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      do_op32(fs[i], xs[i], ys[i], lat, bc);
      // MFHI right after the DIV reads back the new HI (0).
      wres = (i == 5) ? whi[4] : wlo[i];
      tests_run++;
      if (hi !== whi[i] && i != 5 || lo !== wlo[i] || result !== wres ||
          z_flag !== (wres == 0) || lat !== wlat[i] || bc !== wlat[i]) begin
        failed++;
        $display("FAIL muldiv_directed[%0d]: got hi=%h lo=%h r=%h z=%b lat=%0d busy=%0d want hi=%h lo=%h r=%h lat=%0d busy=%0d",
                 i, hi, lo, result, z_flag, lat, bc, whi[i], wlo[i], wres, wlat[i], wlat[i]);
      end
    end
    m_hi = 32'd0; m_lo = 32'h8000_0000;
  endtask

  task automatic test_muldiv_random();
    logic [5:0]  f;
    logic [31:0] x, y, er;
    int el, lat, bc;
    for (int i = 0; i < 40; i++) begin
      f = 6'(24 + $urandom_range(0, 3));
      x = rnd32();
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd32();
      model32(f, x, y, er, el);
      do_op32(f, x, y, lat, bc);
      tests_run++;
      if (result !== er || z_flag !== (er == 0) || hi !== m_hi || lo !== m_lo ||
          lat !== el || bc !== el) begin
        failed++;
        $display("FAIL muldiv_random f=%0d a=%h b=%h: got r=%h hi=%h lo=%h lat=%0d busy=%0d want r=%h hi=%h lo=%h lat=%0d",
                 f, x, y, result, hi, lo, lat, bc, er, m_hi, m_lo, el);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bad;
    logic [31:0] er;
    int el;
    model32(6'd24, 32'd5, 32'd6, er, el);
    @(negedge clk);
    start = 1'b1; func = 6'd24; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    func = 6'd32; a = 32'd123; b = 32'd456;
    lat = 0; bad = 0;
    repeat (10) begin
      if (done) bad++;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    tests_run++;
    if (bad !== 0 || lat !== el || result !== er || hi !== m_hi || lo !== m_lo) begin
      failed++;
      $display("FAIL busy_ignore: got early_done=%0d lat=%0d r=%h hi=%h lo=%h want early_done=0 lat=%0d r=%h hi=%h lo=%h",
               bad, lat, result, hi, lo, el, er, m_hi, m_lo);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL busy_ignore_after: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_unknown();
    int lat, bc;
    logic [31:0] er;
    int el;
    model32(6'd17, 32'hDEAD_BEEF, '0, er, el);
    do_op32(6'd17, 32'hDEAD_BEEF, '0, lat, bc);
    model32(6'd63, 32'h1234_5678, 32'h9, er, el);
    do_op32(6'd63, 32'h1234_5678, 32'h9, lat, bc);
    tests_run++;
    if (result !== 32'd0 || z_flag !== 1'b1 || lat !== 0 || hi !== m_hi || lo !== m_lo) begin
      failed++;
      $display("FAIL unknown_func: got r=%h z=%b lat=%0d hi=%h lo=%h want r=0 z=1 lat=0 hi=%h lo=%h",
               result, z_flag, lat, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_width8();
    int lat;
    do_op8(6'd25, 8'hFF, 8'hFF, lat);
    tests_run++;
    if (hi8 !== 8'hFE || lo8 !== 8'h01 || result8 !== 8'h01 || lat !== 8) begin
      failed++;
      $display("FAIL w8_multu: got hi=%h lo=%h r=%h lat=%0d want hi=fe lo=01 r=01 lat=8", hi8, lo8, result8, lat);
    end
    do_op8(6'd26, 8'h80, 8'hFF, lat);
    tests_run++;
    if (hi8 !== 8'h00 || lo8 !== 8'h80 || lat !== 8) begin
      failed++;
      $display("FAIL w8_div_ovf: got hi=%h lo=%h lat=%0d want hi=00 lo=80 lat=8", hi8, lo8, lat);
    end
    do_op8(6'd27, 8'd200, 8'd7, lat);
    tests_run++;
    if (hi8 !== 8'd4 || lo8 !== 8'd28 || lat !== 8) begin
      failed++;
      $display("FAIL w8_divu: got hi=%h lo=%h lat=%0d want hi=04 lo=1c lat=8", hi8, lo8, lat);
    end
    do_op8(6'd60, 8'h00, 8'h00, lat);
    tests_run++;
    if (result8 !== 8'd8 || lat !== 0) begin
      failed++;
      $display("FAIL w8_clz_zero: got r=%h lat=%0d want r=08 lat=0", result8, lat);
    end
    do_op8(6'd63, 8'h5A, 8'h11, lat);
    tests_run++;
    if (result8 !== 8'h00 || z8 !== 1'b1 || hi8 !== 8'd4 || lo8 !== 8'd28 || lat !== 0) begin
      failed++;
      $display("FAIL w8_unknown: got r=%h z=%b hi=%h lo=%h lat=%0d want r=00 z=1 hi=04 lo=1c lat=0",
               result8, z8, hi8, lo8, lat);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_mul();
    test_single_directed();
    test_random_single();
    test_muldiv_directed();
    test_muldiv_random();
    test_busy_ignore();
    test_unknown();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
